// File: rtl/frame_issuer.sv
// frame_issuer: program store plus PC that fetches frames, issues them on valid/ready and resolves branches locally.
module frame_issuer #(
  parameter int PROG_DEPTH = 256,
  parameter int PC_W = 8,
  parameter int FRAME_W = 17
) (
  input  logic               sysclk,
  input  logic               reset,
  input  logic               load_en,
  input  logic [PC_W-1:0]    load_addr,
  input  logic [FRAME_W-1:0] load_data,
  input  logic               start,
  input  logic [PC_W-1:0]    start_pc,
  input  logic               halt,
  input  logic               eq_flag,
  output logic [FRAME_W-1:0] frame,
  output logic               frame_valid,
  input  logic               frame_ready,
  output logic [PC_W-1:0]    pc,
  output logic               busy,
  output logic               done
);
  typedef enum logic [1:0] {IDLE, FETCH, ISSUE} state_t;
  state_t state;
  logic [FRAME_W-1:0] mem [PROG_DEPTH];
  logic [FRAME_W-1:0] word;
  logic [3:0] op;
  logic jump;
  assign word = mem[pc];
  assign op = frame[FRAME_W-1 -: 4];
  assign jump = op == 4'hC || (op == 4'hD && !eq_flag) || (op == 4'hE && eq_flag);
  assign busy = state != IDLE;
  // The store has no reset so its contents survive a mid-run reset.
  always_ff @(posedge sysclk)
    if (state == IDLE && load_en) mem[load_addr] <= load_data;
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      frame <= '0;
      frame_valid <= 1'b0;
      pc <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          pc <= start_pc;
          state <= FETCH;
        end
        FETCH: if (word[FRAME_W-1 -: 4] == 4'hF) begin
          done <= 1'b1;
          state <= IDLE;
        end else if (halt) begin
          state <= IDLE;
        end else begin
          frame <= word;
          frame_valid <= 1'b1;
          state <= ISSUE;
        end
        ISSUE: if (frame_ready) begin
          frame_valid <= 1'b0;
          pc <= jump ? frame[FRAME_W-5 -: PC_W] : pc + 1'b1;
          state <= halt ? IDLE : FETCH;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_frame_issuer.sv
// tb_frame_issuer: directed vectors with hand-computed expectations for frame_issuer.
module tb_frame_issuer;
  logic sysclk = 0, reset = 1;
  logic load_en = 0, start = 0, halt = 0, eq_flag = 0, frame_ready = 0;
  logic [7:0] load_addr = 0, start_pc = 0;
  logic [16:0] load_data = 0;
  logic [16:0] frame;
  logic frame_valid, busy, done;
  logic [7:0] pc;
  int checks = 0, errors = 0;
  always #5 sysclk = ~sysclk;
  frame_issuer dut (
    .sysclk(sysclk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .start(start), .start_pc(start_pc), .halt(halt),
    .eq_flag(eq_flag), .frame(frame), .frame_valid(frame_valid),
    .frame_ready(frame_ready), .pc(pc), .busy(busy), .done(done)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge sysclk);
    #1;
  endtask
  task automatic load(input logic [7:0] a, input logic [16:0] d);
    load_en = 1; load_addr = a; load_data = d;
    step();
    load_en = 0;
  endtask
  task automatic go(input logic [7:0] a);
    start = 1; start_pc = a;
    step();
    start = 0;
  endtask
  initial begin
    step();
    check("rst_valid", frame_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_pc", pc, 0);
    check("rst_frame", frame, 0);
    check("rst_done", done, 0);
    reset = 0;
    load(8'hFE, 17'h02000);
    load(8'hFF, 17'h04000);
    load(8'h00, 17'h1E000);
    go(8'hFE);
    check("lin_fetch_busy", busy, 1);
    check("lin_fetch_valid", frame_valid, 0);
    check("lin_fetch_pc", pc, 8'hFE);
    step();
    check("lin_v1", frame_valid, 1);
    check("lin_f1", frame, 17'h02000);
    check("lin_pc1", pc, 8'hFE);
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_valid", frame_valid, 1);
      check("bp_frame", frame, 17'h02000);
    end
    frame_ready = 1;
    step();
    check("hs_valid_drop", frame_valid, 0);
    check("hs_pc", pc, 8'hFF);
    step();
    check("lin_v2", frame_valid, 1);
    check("lin_f2", frame, 17'h04000);
    check("lin_pc2", pc, 8'hFF);
    step();
    check("wrap_pc", pc, 8'h00);
    check("wrap_valid", frame_valid, 0);
    step();
    check("end_done", done, 1);
    check("end_busy", busy, 0);
    check("end_pc", pc, 8'h00);
    check("end_valid", frame_valid, 0);
    step();
    check("done_pulse", done, 0);
    load(8'h30, 17'h18800);
    load(8'h40, 17'h1C200);
    load(8'h10, 17'h1A200);
    load(8'h11, 17'h1E000);
    eq_flag = 1;
    go(8'h30);
    step();
    check("jmp_frame", frame, 17'h18800);
    step();
    check("jmp_pc", pc, 8'h40);
    step();
    check("jeq_frame", frame, 17'h1C200);
    step();
    check("jeq_pc", pc, 8'h10);
    step();
    check("jne_frame", frame, 17'h1A200);
    step();
    check("jne_pc", pc, 8'h11);
    step();
    check("br_done", done, 1);
    eq_flag = 0;
    frame_ready = 0;
    load(8'h50, 17'h02000);
    load(8'h51, 17'h04000);
    go(8'h50);
    step();
    halt = 1;
    step();
    check("halt_hold_valid", frame_valid, 1);
    frame_ready = 1;
    step();
    check("halt_accept", frame_valid, 0);
    check("halt_idle", busy, 0);
    check("halt_pc", pc, 8'h51);
    step();
    check("halt_no_issue", frame_valid, 0);
    check("halt_no_done", done, 0);
    check("halt_stay_idle", busy, 0);
    halt = 0;
    frame_ready = 0;
    go(8'h50);
    step();
    check("mr_pre_valid", frame_valid, 1);
    #1 reset = 1;
    #1;
    check("mr_valid", frame_valid, 0);
    check("mr_pc", pc, 0);
    check("mr_busy", busy, 0);
    check("mr_frame", frame, 0);
    reset = 0;
    go(8'h50);
    step();
    check("mr_keep", frame, 17'h02000);
    load(8'h51, 17'h0ABCD);
    check("lr_busy", busy, 1);
    frame_ready = 1;
    step();
    check("lr_pc", pc, 8'h51);
    step();
    check("lr_unchanged", frame, 17'h04000);
    halt = 1;
    step();
    check("lr_idle", busy, 0);
    halt = 0;
    frame_ready = 0;
    load_en = 1; load_addr = 8'h60; load_data = 17'h1E000;
    go(8'h60);
    load_en = 0;
    step();
    check("ls_done", done, 1);
    check("ls_valid", frame_valid, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/frame_issuer.md
# frame_issuer

Instruction-frame sequencer that drives the CPU core's 17-bit `frame` input. It holds a loadable program store and a program counter. It fetches one word per instruction, presents it on a valid/ready handshake, and resolves JMP/JNE/JEQ locally so the core only executes the frames it is given. It sits between the program-load path and the CPU core's frame port.

## Interface
- `PROG_DEPTH`, 256: program store depth in words; equals 2^`PC_W`.
- `PC_W`, 8: program counter width.
- `FRAME_W`, 17: frame width; opcode is `[16:13]`, branch target is `[12:5]`.

Ports:
- `sysclk` in 1: the single clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `load_en` in 1: program-store write strobe; honoured only when `busy`=0.
- `load_addr` in `PC_W`: program-store write address.
- `load_data` in `FRAME_W`: program-store write data.
- `start` in 1: begin issuing at `start_pc`; honoured only when `busy`=0.
- `start_pc` in `PC_W`: entry address.
- `halt` in 1: stop request; level-sampled.
- `eq_flag` in 1: branch condition; sampled at a JNE/JEQ handshake.
- `frame` out `FRAME_W`: frame presented to the core.
- `frame_valid` out 1: `frame` is valid.
- `frame_ready` in 1: the core accepts the frame.
- `pc` out `PC_W`: address of the word currently fetched or issued.
- `busy` out 1: high in FETCH and ISSUE.
- `done` out 1: one-cycle pulse when an END word (opcode 4'hF) is fetched.

## Operation
- States: IDLE, FETCH, ISSUE.
- IDLE:
  - `load_en` writes `load_data` to `mem[load_addr]`.
  - `start` loads `pc`←`start_pc` and moves to FETCH.
  - If `load_en` and `start` are both high, both take effect, and the following fetch sees the written word.
- FETCH: synchronous read of `mem[pc]`.
  - If the opcode is 4'hF: `done`=1 for one cycle, go to IDLE. The word is not issued and `pc` is unchanged.
  - Else if `halt`=1: go to IDLE. No frame is issued and `done` stays 0.
  - Else register the word into `frame`, set `frame_valid`=1, go to ISSUE.
- ISSUE: `frame` and `frame_valid` are held stable until `frame_ready`=1. At the handshake, `frame_valid` drops to 0 the next cycle and `pc` updates:
  - opcode 4'hC (JMP): `pc`←`frame[12:5]`.
  - opcode 4'hD (JNE): `pc`←`frame[12:5]` if `eq_flag`=0, else `pc`+1.
  - opcode 4'hE (JEQ): `pc`←`frame[12:5]` if `eq_flag`=1, else `pc`+1.
  - all other opcodes: `pc`←`pc`+1, modulo 2^`PC_W` (8'hFF wraps to 8'h00).
- After the handshake, go to IDLE if `halt`=1, else go to FETCH.
- `halt` never withdraws a frame that is already valid.
- `load_en` and `start` are ignored while `busy`=1.
- Branch frames are still issued to the core, so the core's jump handling stays consistent with the issuer's.
- `reset` (asynchronous, any state, including mid-handshake):
  - state←IDLE, `frame`←0, `frame_valid`←0, `pc`←0, `busy`←0, `done`←0.
  - Program-store contents are preserved.

## Timing
- `start` sampled in cycle 0 → FETCH in cycle 1 → `frame_valid`=1 in cycle 2.
- Handshake in cycle n → FETCH in n+1 → next `frame_valid` in n+2. Peak throughput is one frame per 2 cycles.
- `frame_valid` is registered. It falls in the cycle after the accepting edge and never drops without a handshake, except on `reset`.
- `done` is asserted in the cycle after the END-word FETCH. `busy` is 0 in that same cycle.
- A program-store write in cycle k is visible to a fetch in cycle k+1 or later.
- `eq_flag` and `halt` are sampled on the same edge as the `frame_ready` handshake.

## Test plan
- Linear run and wrap: load 8'hFE=17'h02000 and 8'hFF=17'h04000, with 8'h00=END. Start at 8'hFE → two frames issued with `pc` 8'hFE then 8'hFF. `pc` wraps to 8'h00, then END → `done` pulse, `busy`=0.
- Backpressure: hold `frame_ready`=0 for 5 cycles → `frame` and `frame_valid` stay constant. On the first `frame_ready`=1, `frame_valid` drops the next cycle.
- Branches: JMP with target 8'h40 → next fetch at 8'h40. JEQ with target 8'h10 and `eq_flag`=1 → `pc`=8'h10. JNE with target 8'h10 and `eq_flag`=1 → `pc`+1.
- Halt: assert `halt` while a frame is pending → the frame is still accepted, no further frame is issued, IDLE is reached, and `done` stays 0.
- Mid-run reset: assert `reset` during ISSUE → `frame_valid`, `pc`, `busy` and `frame` are 0 immediately. Program words are unchanged when read back via a restart.
- Load during run: pulse `load_en` while `busy`=1 → the store is unchanged (verified by a later fetch of that address).
